// File: rtl/mul_err_stats.sv
`default_nettype none
// ============================================================================
// Module   : mul_err_stats
// Purpose  : Error-metrics engine for an approximate signed multiplier.
//            Takes (A, B, R) samples, computes the exact product A*B, and
//            accumulates the sample count, error count, saturating sum of
//            |R - A*B|, and the largest error with the operands that gave it.
//            The optional macro MUL_ERR_BIAS_EN adds an err_bias output,
//            a saturating signed sum of (R - A*B).
// Revision : 1.0 - initial release
// ============================================================================
module mul_err_stats #(
  parameter int W     = 8,
  parameter int CNT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_r,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*W:0]       max_err,
  output logic [W-1:0]       max_a,
  output logic [W-1:0]       max_b
`ifdef MUL_ERR_BIAS_EN
  ,
  output logic [SUM_W-1:0]   err_bias
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             start_ok;

  logic signed [2*W-1:0] exact;
  logic [2*W:0]          diff;

  logic           s1_valid;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [2*W:0]   s1_diff;

  logic [2*W:0]   abs_err;
  logic [SUM_W:0] sum_ext;

  assign in_ready = (state == ST_RUN) && (remaining != '0);
  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Exact product and signed error of the incoming sample (one bit wider than the product)
  always_comb begin
    exact = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});
    diff  = {in_r[2*W-1], in_r} - {exact[2*W-1], exact};
  end

  // Magnitude of the stage-1 error and the widened error sum used for saturation
  always_comb begin
    abs_err = s1_diff[2*W] ? (~s1_diff + (2*W+1)'(1)) : s1_diff;
    sum_ext = {1'b0, err_sum} + (SUM_W+1)'(abs_err);
  end

  // Run control: sample budget and state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            remaining <= n_samples;
            state     <= (n_samples == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        // DRAIN always holds exactly the last sample in stage 1; it retires on this edge
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: capture operands and signed error of the accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_diff <= diff;
      end
    end
  end

  // Stage 2: saturating statistics; strict compare keeps the first maximum on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      max_err    <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else if (start_ok) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      max_err    <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else if (s1_valid) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
      if (abs_err != '0) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        err_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
      if (abs_err > max_err) begin
        max_err <= abs_err;
        max_a   <= s1_a;
        max_b   <= s1_b;
      end
    end
  end

`ifdef MUL_ERR_BIAS_EN
  logic [SUM_W:0] bias_ext;

  // Widened signed bias sum; overflow shows as the top two bits disagreeing
  always_comb begin
    bias_ext = {err_bias[SUM_W-1], err_bias} + {{(SUM_W-2*W){s1_diff[2*W]}}, s1_diff};
  end

  // Stage 2 signed bias accumulator, clamped at the signed limits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bias <= '0;
    end else if (start_ok) begin
      err_bias <= '0;
    end else if (s1_valid) begin
      if (bias_ext[SUM_W] != bias_ext[SUM_W-1])
        err_bias <= bias_ext[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
      else
        err_bias <= bias_ext[SUM_W-1:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_err_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_err_stats
// Purpose  : Scoreboard bench for mul_err_stats. Each run pushes its
//            hand-computed final statistics and done cycle; a monitor pops
//            and compares when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_err_stats;

  localparam int W     = 8;
  localparam int CNT_W = 32;
  localparam int SUM_W = 48;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   n_samples = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_a = '0;
  logic [W-1:0]       in_b = '0;
  logic [2*W-1:0]     in_r = '0;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [SUM_W-1:0]   err_sum;
  logic [2*W:0]       max_err;
  logic [W-1:0]       max_a;
  logic [W-1:0]       max_b;
`ifdef MUL_ERR_BIAS_EN
  logic [SUM_W-1:0]   err_bias;
`endif

  mul_err_stats #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .err_sum(err_sum),
    .max_err(max_err), .max_a(max_a), .max_b(max_b)
`ifdef MUL_ERR_BIAS_EN
    , .err_bias(err_bias)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint scnt;
    longint ecnt;
    longint esum;
    longint merr;
    longint ma;
    longint mb;
    longint bias;
    int     dcyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   sa [0:7];
  int   sbv[0:7];
  int   sr [0:7];

  task automatic check(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(longint s, longint e, longint su, longint m,
                              longint a, longint b, longint bi);
    exp_t x;
    x.scnt = s; x.ecnt = e; x.esum = su; x.merr = m;
    x.ma = a; x.mb = b; x.bias = bi; x.dcyc = 0;
    return x;
  endfunction

  task automatic set_s(input int i, input int a, input int b, input int r);
    sa[i] = a; sbv[i] = b; sr[i] = r;
  endtask

  // Monitor: on each rising done, compare final statistics against the queue head
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.dcyc);
          check("sample_cnt", longint'(sample_cnt), e.scnt);
          check("err_cnt",    longint'(err_cnt),    e.ecnt);
          check("err_sum",    longint'(err_sum),    e.esum);
          check("max_err",    longint'(max_err),    e.merr);
          check("max_a",      longint'(max_a),      e.ma);
          check("max_b",      longint'(max_b),      e.mb);
`ifdef MUL_ERR_BIAS_EN
          check("err_bias",   longint'($signed(err_bias)), e.bias);
`endif
        end
      end
      prev_done = done;
    end
  end

  task automatic pulse_start(input int n);
    start = 1'b1;
    n_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feed n samples back-to-back; returns the cycle count at the last accepting edge
  task automatic feed(input int n, output int last);
    int t;
    last = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a = W'(sa[i]);
      in_b = W'(sbv[i]);
      in_r = (2*W)'(sr[i]);
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk); #1; t++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      last = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input int n, input exp_t e);
    int last;
    int t;
    pulse_start(n);
    if (n == 0) begin
      e.dcyc = cyc;
    end else begin
      feed(n, last);
      e.dcyc = last + 1;
    end
    sb_q.push_back(e);
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int last;
    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact products including the -128*-128 corner
    set_s(0, 3, 5, 15); set_s(1, -4, 6, -24); set_s(2, -128, -128, 16384);
    run(3, mk(3, 0, 0, 0, 0, 0, 0));

    // One error of 3
    set_s(0, 7, 9, 60); set_s(1, 2, 2, 4);
    run(2, mk(2, 1, 3, 3, 7, 9, -3));

    // Equal errors: first maximum kept
    set_s(0, 1, 10, 15); set_s(1, 2, 10, 25); set_s(2, -1, 3, -8);
    run(3, mk(3, 3, 15, 5, 1, 10, 5));

    // Samples offered in DONE are dropped
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_r = 16'd0;
    check("done_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_stats_hold", sample_cnt, 3);
    in_valid = 1'b0;

    // Back to IDLE, samples dropped there too, then an empty run
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    in_valid = 1'b1;
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("idle_stats_hold", sample_cnt, 0);
    in_valid = 1'b0;
    run(0, mk(0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a 10-sample run
    pulse_start(10);
    set_s(0, 7, 9, 60); set_s(1, 1, 10, 15);
    feed(2, last);
    @(posedge clk); #1;
    check("mid_sample_cnt", sample_cnt, 2);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_sample_cnt", sample_cnt, 0);
    check("abort_err_sum", err_sum, 0);
    check("abort_max_err", max_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Largest possible error magnitude
    set_s(0, -128, -128, -32768); set_s(1, 0, 0, 0); set_s(2, -128, -128, 16384);
    run(3, mk(3, 1, 49152, 49152, 128, 128, -49152));

    // Positive and negative errors for the bias sum
    set_s(0, 3, 4, 10); set_s(1, 3, 5, 20);
    run(2, mk(2, 2, 7, 5, 3, 5, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
